// File: rtl/opb_reg_pkg.sv
// opb_reg_pkg: shared FSM states, word-index width and OPB byte-lane helper for the OPB register slaves
package opb_reg_pkg;

    typedef enum logic {IDLE, ACK} state_t;

    localparam int IDX_W = 4;

    // be[3] is OPB BE[0], which owns word bits 31:24
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/opb_addr_decode.sv
// opb_addr_decode: combinational window hit and word index for an OPB slave register bank
module opb_addr_decode
    import opb_reg_pkg::*;
#(
    parameter int C_OPB_AWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR = 32'h01001300,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR = 32'h010013FF
)(
    input  logic [0:C_OPB_AWIDTH-1] abus,
    input  logic                    select,
    output logic                    hit,
    output logic [IDX_W-1:0]        idx
);

    logic [C_OPB_AWIDTH-1:0] addr;

    assign addr = abus;
    assign hit  = select && addr >= C_BASEADDR && addr <= C_HIGHADDR;
    assign idx  = abus[C_OPB_AWIDTH-3-:IDX_W];

endmodule

// File: rtl/opb_register_ppc2simulink_bank.sv
// opb_register_ppc2simulink_bank: PPC-writable OPB register bank feeding fabric; define OPB_REG_DOUBLE_BUFFER_EN for shadow/commit buffering
module opb_register_ppc2simulink_bank
    import opb_reg_pkg::*;
#(
    parameter int C_OPB_AWIDTH = 32,
    parameter int C_OPB_DWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR = 32'h01001300,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR = 32'h010013FF,
    parameter int C_NUM_REGS = 4,
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000,
    parameter C_FAMILY = "virtex5"
)(
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic                      Sl_xferAck,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_wr_strobe
);

    localparam logic [IDX_W:0] NUM = (IDX_W+1)'(C_NUM_REGS);

    state_t                       state, state_n;
    logic                         hit, ack, rnw_q;
    logic [IDX_W-1:0]             idx, idx_q;
    logic [31:0]                  data_q, mask_q, rdata;
    logic [C_NUM_REGS-1:0][31:0]  shadow;
    logic                         unused_ok;

    opb_addr_decode #(
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR)
    ) u_decode (
        .abus   (OPB_ABus),
        .select (OPB_select),
        .hit    (hit),
        .idx    (idx)
    );

`ifdef OPB_REG_DOUBLE_BUFFER_EN
    logic [C_NUM_REGS-1:0][31:0] active;
    logic                        commit;
    assign commit        = {1'b0, idx_q} == NUM && data_q[0];
    assign user_data_out = active;
`else
    assign user_data_out = shadow;
`endif

    assign unused_ok  = OPB_seqAddr ^ (|C_FAMILY);
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    // reset in the ACK cycle kills the ack so an abandoned transfer never completes
    assign ack        = state == ACK && !OPB_Rst;
    assign Sl_xferAck = ack;
    assign Sl_DBus    = (ack && rnw_q) ? rdata : '0;

    // state register
    always_ff @(posedge OPB_Clk)
        state <= OPB_Rst ? IDLE : state_n;

    // every hit gets exactly one ACK cycle, then back to IDLE
    always_comb
        state_n = (state == IDLE && hit) ? ACK : IDLE;

    // capture the request while accepting it in IDLE
    always_ff @(posedge OPB_Clk)
        if (OPB_Rst) begin
            idx_q  <= '0;
            data_q <= '0;
            mask_q <= '0;
            rnw_q  <= 1'b0;
        end else if (state == IDLE && hit) begin
            idx_q  <= idx;
            data_q <= OPB_DBus;
            mask_q <= lane_mask(OPB_BE);
            rnw_q  <= OPB_RNW;
        end

    // readback mux; indices past the last word read as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (idx_q == IDX_W'(i)) rdata = shadow[i];
    end

    // byte-lane write at the end of a write ACK, strobe aligned with the new data
    always_ff @(posedge OPB_Clk)
        if (OPB_Rst) begin
            shadow         <= {C_NUM_REGS{C_RESET_VALUE}};
            user_wr_strobe <= '0;
`ifdef OPB_REG_DOUBLE_BUFFER_EN
            active         <= {C_NUM_REGS{C_RESET_VALUE}};
`endif
        end else begin
            user_wr_strobe <= '0;
            for (int i = 0; i < C_NUM_REGS; i++)
                if (ack && !rnw_q && idx_q == IDX_W'(i)) begin
                    shadow[i] <= (shadow[i] & ~mask_q) | (data_q & mask_q);
`ifndef OPB_REG_DOUBLE_BUFFER_EN
                    user_wr_strobe[i] <= 1'b1;
`endif
                end
`ifdef OPB_REG_DOUBLE_BUFFER_EN
            if (ack && !rnw_q && commit) begin
                active         <= shadow;
                user_wr_strobe <= '1;
            end
`endif
        end

endmodule

// File: tb/tb_opb_register_ppc2simulink_bank.sv
// tb_opb_register_ppc2simulink_bank: randomized and directed checks of the OPB register bank against a word-level model
module tb_opb_register_ppc2simulink_bank;

    localparam logic [31:0] BASE = 32'h01001300;
    localparam int N = 4;

    logic         OPB_Clk = 1'b0;
    logic         OPB_Rst = 1'b1;
    logic [0:31]  OPB_ABus = '0;
    logic [0:3]   OPB_BE = '0;
    logic [0:31]  OPB_DBus = '0;
    logic         OPB_RNW = 1'b0;
    logic         OPB_select = 1'b0;
    logic         OPB_seqAddr = 1'b0;
    logic [0:31]  Sl_DBus;
    logic         Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck;
    logic [127:0] user_data_out;
    logic [3:0]   user_wr_strobe;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_sh [N];
    logic [31:0] m_act [N];

    opb_register_ppc2simulink_bank dut (
        .OPB_Clk        (OPB_Clk),
        .OPB_Rst        (OPB_Rst),
        .OPB_ABus       (OPB_ABus),
        .OPB_BE         (OPB_BE),
        .OPB_DBus       (OPB_DBus),
        .OPB_RNW        (OPB_RNW),
        .OPB_select     (OPB_select),
        .OPB_seqAddr    (OPB_seqAddr),
        .Sl_DBus        (Sl_DBus),
        .Sl_errAck      (Sl_errAck),
        .Sl_retry       (Sl_retry),
        .Sl_toutSup     (Sl_toutSup),
        .Sl_xferAck     (Sl_xferAck),
        .user_data_out  (user_data_out),
        .user_wr_strobe (user_wr_strobe)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [0:3] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[31-8*b -: 8] = d[31-8*b -: 8];
        return r;
    endfunction

    function automatic logic [127:0] vis();
        return {m_act[3], m_act[2], m_act[1], m_act[0]};
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        return idx < N ? m_sh[idx] : 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh[i]  = 32'h0;
            m_act[i] = 32'h0;
        end
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [0:3] be, output logic [3:0] stb);
        stb = 4'h0;
`ifdef OPB_REG_DOUBLE_BUFFER_EN
        if (idx < N) m_sh[idx] = merge(m_sh[idx], d, be);
        else if (idx == N && d[0]) begin
            for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
            stb = 4'hF;
        end
`else
        if (idx < N) begin
            m_sh[idx]  = merge(m_sh[idx], d, be);
            m_act[idx] = m_sh[idx];
            stb[idx]   = 1'b1;
        end
`endif
    endtask

    // one OPB transfer; returns at #1 after the edge following the ack (strobe cycle)
    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [0:3] be, input logic [31:0] d,
                        output logic acked, output int lat, output logic [31:0] rd, output logic leak);
        @(negedge OPB_Clk);
        OPB_ABus = addr; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = d; OPB_select = 1'b1;
        acked = 1'b0; lat = 0; rd = '0; leak = 1'b0;
        for (int c = 1; c <= 4 && !acked; c++) begin
            @(posedge OPB_Clk); #1;
            if (Sl_xferAck) begin
                acked = 1'b1; lat = c; rd = Sl_DBus; OPB_select = 1'b0;
            end else if (Sl_DBus !== 32'h0) leak = 1'b1;
        end
        OPB_select = 1'b0;
        if (acked) begin
            @(posedge OPB_Clk); #1;
            if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) leak = 1'b1;
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge OPB_Clk);
        #1;
        n_cmp++; if (Sl_xferAck !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", Sl_xferAck); end
        n_cmp++; if (Sl_DBus !== 32'h0) begin n_bad++; $display("FAIL reset_dbus: got %h want 0", Sl_DBus); end
        n_cmp++; if (user_data_out !== vis()) begin n_bad++; $display("FAIL reset_data: got %h want %h", user_data_out, vis()); end
        n_cmp++; if (user_wr_strobe !== 4'h0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0000", user_wr_strobe); end
        n_cmp++; if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin n_bad++; $display("FAIL tied_outputs: got %b want 000", {Sl_errAck, Sl_retry, Sl_toutSup}); end
        @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
    endtask

    task automatic test_read_after_reset();
        logic acked, leak; int lat; logic [31:0] rd;
        xfer(BASE, 1'b1, 4'hF, 32'h0, acked, lat, rd, leak);
        n_cmp++; if (!(acked && lat == 1)) begin n_bad++; $display("FAIL read0_latency: got ack=%b lat=%0d want ack=1 lat=1", acked, lat); end
        n_cmp++; if (rd !== model_read(0)) begin n_bad++; $display("FAIL read0_data: got %h want %h", rd, model_read(0)); end
        n_cmp++; if (leak) begin n_bad++; $display("FAIL read0_dbus_idle: got nonzero bus or repeat ack want quiet bus"); end
    endtask

    task automatic test_full_write();
        logic acked, leak; int lat; logic [31:0] rd; logic [3:0] stb;
        xfer(BASE + 32'h4, 1'b0, 4'hF, 32'hDEADBEEF, acked, lat, rd, leak);
        model_write(1, 32'hDEADBEEF, 4'hF, stb);
        n_cmp++; if (!(acked && lat == 1 && !leak)) begin n_bad++; $display("FAIL full_wr_ack: got ack=%b lat=%0d leak=%b want 1/1/0", acked, lat, leak); end
        n_cmp++; if (user_wr_strobe !== stb) begin n_bad++; $display("FAIL full_wr_strobe: got %b want %b", user_wr_strobe, stb); end
        n_cmp++; if (user_data_out !== vis()) begin n_bad++; $display("FAIL full_wr_data: got %h want %h", user_data_out, vis()); end
        @(posedge OPB_Clk); #1;
        n_cmp++; if (user_wr_strobe !== 4'h0) begin n_bad++; $display("FAIL full_wr_strobe_width: got %b want 0000", user_wr_strobe); end
        xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, acked, lat, rd, leak);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL full_wr_readback: got %h want deadbeef", rd); end
    endtask

    task automatic test_partial_write();
        logic acked, leak; int lat; logic [31:0] rd; logic [3:0] stb;
        xfer(BASE + 32'h4, 1'b0, 4'b0101, 32'h11223344, acked, lat, rd, leak);
        model_write(1, 32'h11223344, 4'b0101, stb);
        n_cmp++; if (user_wr_strobe !== stb) begin n_bad++; $display("FAIL part_wr_strobe: got %b want %b", user_wr_strobe, stb); end
        n_cmp++; if (user_data_out !== vis()) begin n_bad++; $display("FAIL part_wr_data: got %h want %h", user_data_out, vis()); end
        xfer(BASE + 32'h4, 1'b1, 4'hF, 32'h0, acked, lat, rd, leak);
        n_cmp++; if (rd !== 32'hDE22BE44) begin n_bad++; $display("FAIL part_wr_readback: got %h want de22be44", rd); end
    endtask

    task automatic test_be_zero();
        logic acked, leak; int lat; logic [31:0] rd; logic [3:0] stb;
        xfer(BASE + 32'h8, 1'b0, 4'b0000, 32'hFFFFFFFF, acked, lat, rd, leak);
        model_write(2, 32'hFFFFFFFF, 4'b0000, stb);
        n_cmp++; if (!acked) begin n_bad++; $display("FAIL be0_ack: got 0 want 1"); end
        n_cmp++; if (user_wr_strobe !== stb) begin n_bad++; $display("FAIL be0_strobe: got %b want %b", user_wr_strobe, stb); end
        n_cmp++; if (user_data_out !== vis()) begin n_bad++; $display("FAIL be0_data: got %h want %h", user_data_out, vis()); end
    endtask

    task automatic test_out_of_range();
        logic acked, leak; int lat; logic [31:0] rd; logic [3:0] stb;
        xfer(BASE + 32'h20, 1'b0, 4'hF, 32'hCAFEF00D, acked, lat, rd, leak);
        model_write(8, 32'hCAFEF00D, 4'hF, stb);
        n_cmp++; if (!(acked && lat == 1)) begin n_bad++; $display("FAIL oor_wr_ack: got ack=%b lat=%0d want 1/1", acked, lat); end
        n_cmp++; if (user_wr_strobe !== stb) begin n_bad++; $display("FAIL oor_wr_strobe: got %b want %b", user_wr_strobe, stb); end
        n_cmp++; if (user_data_out !== vis()) begin n_bad++; $display("FAIL oor_wr_data: got %h want %h", user_data_out, vis()); end
        xfer(BASE + 32'h20, 1'b1, 4'hF, 32'h0, acked, lat, rd, leak);
        n_cmp++; if (!acked || rd !== 32'h0) begin n_bad++; $display("FAIL oor_rd: got ack=%b data=%h want ack=1 data=0", acked, rd); end
        xfer(BASE + 32'h100, 1'b0, 4'hF, 32'h12345678, acked, lat, rd, leak);
        n_cmp++; if (acked !== 1'b0 || leak) begin n_bad++; $display("FAIL outside_above: got ack=%b leak=%b want no ack", acked, leak); end
        n_cmp++; if (user_data_out !== vis()) begin n_bad++; $display("FAIL outside_data: got %h want %h", user_data_out, vis()); end
        xfer(BASE - 32'h4, 1'b1, 4'hF, 32'h0, acked, lat, rd, leak);
        n_cmp++; if (acked !== 1'b0) begin n_bad++; $display("FAIL outside_below: got ack=%b want 0", acked); end
    endtask

    task automatic test_back_to_back_random();
        logic acked, leak; int lat; logic [31:0] rd, d; logic [3:0] stb; logic [0:3] be; logic rnw; int idx;
        for (int k = 0; k < 48; k++) begin
            idx = $urandom_range(0, 5);
            rnw = 1'($urandom_range(0, 1));
            be  = 4'($urandom);
            d   = $urandom;
            xfer(BASE + 32'(idx * 4), rnw, be, d, acked, lat, rd, leak);
            n_cmp++; if (!(acked && lat == 1 && !leak)) begin n_bad++; $display("FAIL rnd_xfer[%0d]: got ack=%b lat=%0d leak=%b want 1/1/0", k, acked, lat, leak); end
            if (rnw) begin
                n_cmp++; if (rd !== model_read(idx)) begin n_bad++; $display("FAIL rnd_rd[%0d] idx %0d: got %h want %h", k, idx, rd, model_read(idx)); end
            end else begin
                model_write(idx, d, be, stb);
                n_cmp++; if (user_wr_strobe !== stb) begin n_bad++; $display("FAIL rnd_strobe[%0d] idx %0d: got %b want %b", k, idx, user_wr_strobe, stb); end
                n_cmp++; if (user_data_out !== vis()) begin n_bad++; $display("FAIL rnd_data[%0d] idx %0d: got %h want %h", k, idx, user_data_out, vis()); end
            end
        end
    endtask

    task automatic test_reset_in_ack();
        logic acked, leak; int lat; logic [31:0] rd;
        @(negedge OPB_Clk);
        OPB_ABus = BASE + 32'h8; OPB_RNW = 1'b0; OPB_BE = 4'hF; OPB_DBus = 32'h13572468; OPB_select = 1'b1;
        @(posedge OPB_Clk); #1;
        OPB_Rst = 1'b1;
        #1;
        n_cmp++; if (Sl_xferAck !== 1'b0) begin n_bad++; $display("FAIL rst_ack_cycle: got ack=%b want 0", Sl_xferAck); end
        OPB_select = 1'b0;
        model_reset();
        @(posedge OPB_Clk); #1;
        OPB_Rst = 1'b0;
        n_cmp++; if (user_data_out !== vis()) begin n_bad++; $display("FAIL rst_ack_data: got %h want %h", user_data_out, vis()); end
        n_cmp++; if (user_wr_strobe !== 4'h0 || Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) begin n_bad++; $display("FAIL rst_ack_outputs: got strobe=%b ack=%b dbus=%h want 0/0/0", user_wr_strobe, Sl_xferAck, Sl_DBus); end
        xfer(BASE + 32'h8, 1'b1, 4'hF, 32'h0, acked, lat, rd, leak);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_ack_readback: got %h want 0", rd); end
    endtask

`ifdef OPB_REG_DOUBLE_BUFFER_EN
    task automatic test_double_buffer();
        logic acked, leak; int lat; logic [31:0] rd, before; logic [3:0] stb;
        before = user_data_out[95:64];
        xfer(BASE + 32'h8, 1'b0, 4'hF, 32'hA5A5A5A5, acked, lat, rd, leak);
        model_write(2, 32'hA5A5A5A5, 4'hF, stb);
        n_cmp++; if (user_data_out[95:64] !== before || user_wr_strobe !== 4'h0) begin n_bad++; $display("FAIL db_shadow: got %h/%b want %h/0000", user_data_out[95:64], user_wr_strobe, before); end
        xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h0, acked, lat, rd, leak);
        model_write(4, 32'h0, 4'hF, stb);
        n_cmp++; if (!acked || user_data_out[95:64] !== before || user_wr_strobe !== 4'h0) begin n_bad++; $display("FAIL db_commit_lsb0: got ack=%b %h/%b want 1 %h/0000", acked, user_data_out[95:64], user_wr_strobe, before); end
        xfer(BASE + 32'h10, 1'b0, 4'hF, 32'h1, acked, lat, rd, leak);
        model_write(4, 32'h1, 4'hF, stb);
        n_cmp++; if (user_data_out[95:64] !== 32'hA5A5A5A5 || user_data_out !== vis()) begin n_bad++; $display("FAIL db_commit_data: got %h want %h", user_data_out, vis()); end
        n_cmp++; if (user_wr_strobe !== 4'hF) begin n_bad++; $display("FAIL db_commit_strobe: got %b want 1111", user_wr_strobe); end
        @(posedge OPB_Clk); #1;
        n_cmp++; if (user_wr_strobe !== 4'h0) begin n_bad++; $display("FAIL db_commit_width: got %b want 0000", user_wr_strobe); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_after_reset();
        test_full_write();
        test_partial_write();
        test_be_zero();
        test_out_of_range();
`ifdef OPB_REG_DOUBLE_BUFFER_EN
        test_double_buffer();
`endif
        test_back_to_back_random();
        test_reset_in_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/opb_register_ppc2simulink_bank.md
Name: opb_register_ppc2simulink_bank

Overview:
- OPB slave register bank carrying PPC-written control words into the Simulink fabric.
- Opposite direction to the simulink2ppc readout registers: PPC writes and reads back; fabric only reads `user_data_out` and sees a per-word update strobe.
- Sits on the shared OPB next to the existing simulink2ppc slaves; single clock domain (OPB_Clk).

Parameters:
- C_BASEADDR, 32'h01001300, first byte address of the bank.
- C_HIGHADDR, 32'h010013FF, last byte address decoded (hit window).
- C_NUM_REGS, 4, number of 32-bit words (1..16).
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_RESET_VALUE, 32'h00000000, reset content of every word.
- C_FAMILY, "virtex5", target family (informational).

Ports:
- OPB_Clk  in  1  sole clock; all logic rising-edge.
- OPB_Rst  in  1  synchronous, active-high reset.
- OPB_ABus  in  [0:31]  address, bit 0 = MSB.
- OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7] (word bits 31:24).
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored (no burst support).
- Sl_DBus  out  [0:31]  read data; zero except during a read ack.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- user_data_out  out  [32*C_NUM_REGS-1:0]  word i at bits [32i+31:32i].
- user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse when word i changes visibility.

Behaviour:
- Reset: synchronous, active-high on OPB_Rst.
  - Sl_DBus=0, Sl_xferAck=0, all words = C_RESET_VALUE, user_wr_strobe=0, FSM=IDLE.
  - A transfer in flight is abandoned with no ack; the master times out.
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Word index: OPB_ABus[C_OPB_AWIDTH-3-:4], i.e. byte address bits [5:2] relative to base.
- FSM IDLE:
  - On hit, latch addr, BE, DBus and RNW; go to ACK.
  - No hit: stay in IDLE.
- FSM ACK:
  - Sl_xferAck=1 for exactly this cycle.
  - Read: Sl_DBus = word[idx], bit-reversed to OPB order.
  - Write: each byte lane with BE=1 updates word[idx], effective at the end of this cycle.
  - Go to IDLE.
  - Latency: ack in the second cycle after select rises; back-to-back transfers are accepted every 2 cycles.
- Master drops select the cycle after ack, so IDLE never double-accepts. If select is still high in IDLE with the same address, it is treated as a new transfer.
- idx >= C_NUM_REGS inside the window: acked normally; read returns 0; write ignored; no strobe.
- BE=0000 write: acked; no data change; strobe still pulses.
- user_wr_strobe[idx] pulses high the cycle after the ACK of a write, aligned with the new user_data_out.
- Sl_DBus is forced to 0 in every cycle except a read ACK (wired-OR bus rule).

Optional Feature:
- Macro: OPB_REG_DOUBLE_BUFFER_EN.
- Enabled:
  - Writes land in shadow registers; user_data_out holds the active copy.
  - A write to word index C_NUM_REGS (commit address) with data bit 0 (LSB) = 1 copies all shadows to active in one cycle.
  - That commit pulses user_wr_strobe for all bits simultaneously.
  - Reads return shadow contents.
  - A commit with LSB=0 is acked with no effect.
- Disabled:
  - Writes are immediately visible.
  - The commit address behaves as out-of-range.

Decomposition:
- Shared package opb_reg_pkg:
  - FSM state enum {IDLE, ACK}.
  - Word index width constant (4).
  - Byte-lane mapping function (OPB bit order to little-endian word).
- Sub-module opb_addr_decode: combinational hit flag and word index from ABus, C_BASEADDR and C_HIGHADDR. Reused by the simulink2ppc registers.

Test Plan:
- Reset, then read word 0 → Sl_xferAck pulses once 2 cycles after select; Sl_DBus=C_RESET_VALUE; Sl_DBus=0 on every other cycle.
- Write 0xDEADBEEF to base+0x4, BE=1111 → user_data_out[63:32]=0xDEADBEEF and user_wr_strobe=0010 the cycle after ack; readback gives 0xDEADBEEF.
- Write 0x11223344 to base+0x4 with BE=0101 over 0xDEADBEEF → word becomes 0xDE22BE44.
- Write to base+0x20 (idx 8 >= 4) and to an address outside the window → in-window: acked, no change, read returns 0; out-of-window: no ack.
- OPB_Rst asserted in the ACK cycle of a write → no data change, Sl_xferAck=0, all outputs at reset values on the next cycle.
- With OPB_REG_DOUBLE_BUFFER_EN: write word 2 = 0xA5A5A5A5 → user_data_out unchanged; write 1 to base+0x10 → word 2 becomes visible and user_wr_strobe=1111 for one cycle.
